// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the core: datapath width, reset vector, NOP encoding and base opcodes.
// Also holds the fetch-buffer entry layout used by the fetch unit.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Instruction fetches are always word aligned; low address bits are discarded.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush and occupancy count; the head entry is read straight from storage,
// so a pushed entry is first visible the cycle after the push.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Flush dominates; a push into a full FIFO is only accepted alongside a pop.
  assign do_pop  = pop && (count != '0) && !flush;
  assign do_push = push && !flush && ((count != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// RV32I fetch front end: PC, credit-limited imem request issue, in-order response buffering and
// redirect handling that discards every response still in flight when a branch/jump is taken.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC        = RESET_PC_DEFAULT,
  parameter int              FIFO_DEPTH      = 4,
  parameter int              MAX_OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [6:0]      op
);

  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam int OCW = $clog2(MAX_OUTSTANDING + 1);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rsp_pc;
  logic [OCW-1:0]  outstanding;
  logic [OCW-1:0]  drop_cnt;
  logic [FCW-1:0]  fifo_count;
  fetch_entry_t    head;
  fetch_entry_t    rsp_entry;
  logic            credit_ok;
  logic            req_fire;
  logic            rsp_keep;

  // Only issue when the response is guaranteed a buffer slot, counting everything already in flight.
  assign credit_ok = (32'(outstanding) < MAX_OUTSTANDING) &&
                     ((32'(outstanding) + 32'(fifo_count)) < 32'(FIFO_DEPTH));

  assign imem_req_valid = rst_n && !redirect_valid && credit_ok;
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_keep       = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
  assign rsp_entry      = '{pc: rsp_pc, instr: imem_rsp_data};

  // The tag queue occupancy is the number of accepted-but-unanswered requests.
  fetch_fifo #(
    .WIDTH (XLEN),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (req_fire),
    .push_data (pc),
    .pop       (imem_rsp_valid),
    .flush     (1'b0),
    .count     (outstanding),
    .head_data (rsp_pc)
  );

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_instr_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rsp_keep),
    .push_data (rsp_entry),
    .pop       (instr_valid && instr_ready),
    .flush     (redirect_valid),
    .count     (fifo_count),
    .head_data (head)
  );

  // A redirect drops every response still owed, including one arriving in the redirect cycle itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      drop_cnt <= '0;
    end else begin
      if (redirect_valid) begin
        pc <= word_align(redirect_pc);
      end else if (req_fire) begin
        pc <= pc + 32'd4;
      end

      if (redirect_valid) begin
        drop_cnt <= (imem_rsp_valid && (outstanding != '0)) ? outstanding - 1'b1 : outstanding;
      end else if (imem_rsp_valid && (drop_cnt != '0)) begin
        drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

  assign instr_valid = (fifo_count != '0);
  assign instr       = instr_valid ? head.instr : NOP_INSTR;
  assign instr_pc    = instr_valid ? head.pc : '0;
  assign op          = instr[6:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboarded bench for instr_fetch_unit: an in-order imem model with random latency feeds the DUT,
// and the expected decode stream is the sequential PC run restarted at every reset or redirect.
module tb_instr_fetch_unit;
  import riscv_pkg::*;

  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          ready_at;
  } pend_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'hDEAD_BEEF;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [6:0]  op;

  logic        req2_valid;
  logic [31:0] req2_addr;
  logic        rsp2_valid = 1'b0;
  logic        acc2 = 1'b0;
  logic        instr2_valid;
  logic [31:0] instr2;
  logic [31:0] instr2_pc;
  logic [6:0]  op2;
  logic        tie_one = 1'b1;
  logic        tie_zero = 1'b0;
  logic [31:0] tie_nop = NOP_INSTR;
  logic [31:0] tie_addr = 32'h0;

  int          compared = 0;
  int          mismatched = 0;
  int          cyc = 0;
  int          handshakes = 0;
  int          lat_min = 0;
  int          lat_max = 0;
  exp_t        exp_q[$];
  pend_t       pend_q[$];
  logic [31:0] addr2_q[$];
  logic [31:0] pc2_q[$];
  logic [31:0] next_pc = 32'h0;
  logic        redirect_pending = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr = 32'h0;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .op             (op)
  );

  instr_fetch_unit #(.RESET_PC(WRAP_PC)) dut_wrap (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (req2_valid),
    .imem_req_ready (tie_one),
    .imem_req_addr  (req2_addr),
    .imem_rsp_valid (rsp2_valid),
    .imem_rsp_data  (tie_nop),
    .redirect_valid (tie_zero),
    .redirect_pc    (tie_addr),
    .instr_valid    (instr2_valid),
    .instr_ready    (tie_one),
    .instr          (instr2),
    .instr_pc       (instr2_pc),
    .op             (op2)
  );

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000 ^ {25'd0, a[8:2]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  function automatic void topUp();
    while (exp_q.size() < 8) begin
      exp_q.push_back('{pc: next_pc, word: memWord(next_pc)});
      next_pc = next_pc + 32'd4;
    end
  endfunction

  function automatic void startRedirect(input logic [31:0] target);
    redirect_valid   = 1'b1;
    redirect_pc      = target;
    redirect_pending = 1'b1;
    redirect_target  = {target[31:2], 2'b00};
  endfunction

  // Drives one cycle of inputs; a redirect issued last cycle restarts the expected stream now,
  // after the monitor has already checked any handshake from the redirect cycle.
  task automatic applyStimulus(input logic rdy, input logic irdy, input logic redir, input logic [31:0] target);
    @(posedge clk);
    #2;
    if (redirect_pending) begin
      exp_q.delete();
      next_pc          = redirect_target;
      redirect_pending = 1'b0;
    end
    imem_req_ready = rdy;
    instr_ready    = irdy;
    redirect_valid = 1'b0;
    if (redir) startRedirect(target);
    topUp();
  endtask

  task automatic doReset(input bit checkMid);
    @(posedge clk);
    #2;
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    #1;
    if (checkMid) begin
      checkOutput("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
      checkOutput("rst_instr", instr, NOP_INSTR);
      checkOutput("rst_op", {25'd0, op}, 32'h13);
      checkOutput("rst_instr_pc", instr_pc, 32'h0);
      checkOutput("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    end
    repeat (2) @(posedge clk);
    #2;
    exp_q.delete();
    next_pc          = 32'h0;
    redirect_pending = 1'b0;
    imem_req_ready   = 1'b1;
    instr_ready      = 1'b1;
    rst_n            = 1'b1;
    topUp();
  endtask

  // In-order imem: each accepted request is answered no earlier than the next cycle.
  always @(negedge clk) begin
    if (!rst_n) pend_q.delete();
    else if (imem_req_valid && imem_req_ready)
      pend_q.push_back('{addr: imem_req_addr, ready_at: cyc + 1 + int'($urandom_range(lat_max, lat_min))});
  end

  always @(posedge clk) begin
    cyc++;
    #1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'hDEAD_BEEF;
    if (rst_n && (pend_q.size() > 0) && (pend_q[0].ready_at <= cyc)) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memWord(pend_q[0].addr);
      void'(pend_q.pop_front());
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (instr_valid && instr_ready) begin
        handshakes++;
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL scoreboard_empty: got pc %h, expected no instruction", instr_pc);
        end else begin
          e = exp_q.pop_front();
          checkOutput("instr_pc", instr_pc, e.pc);
          checkOutput("instr", instr, e.word);
          checkOutput("op", {25'd0, op}, {25'd0, e.word[6:0]});
        end
      end else if (!instr_valid) begin
        checkOutput("idle_instr", instr, NOP_INSTR);
        checkOutput("idle_pc", instr_pc, 32'h0);
        checkOutput("idle_op", {25'd0, op}, 32'h13);
      end
      if (prev_stall && imem_req_valid) checkOutput("req_addr_stable", imem_req_addr, prev_addr);
      if (imem_req_valid) checkOutput("req_addr_align", {30'd0, imem_req_addr[1:0]}, 32'h0);
      prev_stall = imem_req_valid && !imem_req_ready;
      prev_addr  = imem_req_addr;
    end
  end

  // Wrap-around instance: one-cycle imem, always ready; record the first addresses and PCs.
  always @(negedge clk) begin
    acc2 = rst_n && req2_valid;
    if (acc2 && (addr2_q.size() < 4)) addr2_q.push_back(req2_addr);
    if (rst_n && instr2_valid && (pc2_q.size() < 3)) pc2_q.push_back(instr2_pc);
  end

  always @(posedge clk) begin
    #1;
    rsp2_valid = rst_n && acc2;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] wrap_addr [4];
    logic [31:0] target;
    int          r;
    bit          found;
    wrap_addr[0] = 32'hFFFF_FFF8;
    wrap_addr[1] = 32'hFFFF_FFFC;
    wrap_addr[2] = 32'h0000_0000;
    wrap_addr[3] = 32'h0000_0004;

    // 1: single-cycle imem, everything ready: 2-cycle fill, then one instruction per cycle
    doReset(1'b0);
    @(negedge clk);
    checkOutput("t1_req_valid", {31'd0, imem_req_valid}, 32'd1);
    checkOutput("t1_req_addr", imem_req_addr, 32'h0);
    checkOutput("t1_valid_c0", {31'd0, instr_valid}, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("t1_valid_c1", {31'd0, instr_valid}, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("t1_valid_c2", {31'd0, instr_valid}, 32'd1);
    checkOutput("t1_first_pc", instr_pc, 32'h0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      @(negedge clk);
      checkOutput("t1_streaming", {31'd0, instr_valid}, 32'd1);
    end

    // 2: decode stalls, buffer fills, fetch stops; release drains without a bubble
    repeat (10) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("t2_full_valid", {31'd0, instr_valid}, 32'd1);
    checkOutput("t2_req_blocked", {31'd0, imem_req_valid}, 32'd0);
    checkOutput("t2_next_addr", imem_req_addr, instr_pc + 32'd16);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      @(negedge clk);
      checkOutput("t2_no_gap", {31'd0, instr_valid}, 32'd1);
    end

    // 3: slow imem keeps two requests in flight, then redirect to 0x100
    lat_min = 2;
    lat_max = 2;
    repeat (8) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h100);
    @(negedge clk);
    checkOutput("t3_no_req_redirect", {31'd0, imem_req_valid}, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("t3_flushed", {31'd0, instr_valid}, 32'd0);
    checkOutput("t3_req_addr", imem_req_addr, 32'h100);
    repeat (12) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);

    // 4: misaligned redirect landing in the same cycle as a response
    lat_min = 0;
    lat_max = 0;
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      if (imem_rsp_valid) begin
        startRedirect(32'h203);
        found = 1'b1;
      end
    end
    if (!found) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL t4_rsp_wait: got no response in 20 cycles, expected one");
    end
    @(negedge clk);
    checkOutput("t4_no_req_redirect", {31'd0, imem_req_valid}, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("t4_flushed", {31'd0, instr_valid}, 32'd0);
    checkOutput("t4_req_valid", {31'd0, imem_req_valid}, 32'd1);
    checkOutput("t4_req_addr", imem_req_addr, 32'h200);
    repeat (10) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);

    // 6: reset with a full buffer; outputs idle at once, fetch restarts at the reset vector
    repeat (10) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    doReset(1'b1);
    @(negedge clk);
    checkOutput("t6_req_valid", {31'd0, imem_req_valid}, 32'd1);
    checkOutput("t6_req_addr", imem_req_addr, 32'h0);
    repeat (10) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);

    // Random traffic: backpressure on both sides, variable latency, occasional redirects
    lat_min = 0;
    lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(99, 0));
      target = (r == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0))) : 32'($urandom_range(32'hFFFF, 0));
      applyStimulus($urandom_range(9, 0) < 7, $urandom_range(9, 0) < 7, r < 3, target);
    end
    repeat (20) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("progress", (handshakes > 500) ? 32'd1 : 32'd0, 32'd1);

    // 5: wrap-around instance
    if (addr2_q.size() < 4 || pc2_q.size() < 3) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL wrap_capture: got %0d addrs/%0d pcs, expected 4/3", addr2_q.size(), pc2_q.size());
    end else begin
      for (int i = 0; i < 4; i++) checkOutput("wrap_addr", addr2_q[i], wrap_addr[i]);
      for (int i = 0; i < 3; i++) checkOutput("wrap_instr_pc", pc2_q[i], wrap_addr[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
